// File: rtl/i2c_cmd_arbiter.sv
// i2c_cmd_arbiter: round-robin, transaction-locked sharing of one i2c_master command port.
// Latency: grant registered one cycle after request in IDLE; owner strobe reaches m_stb combinationally.
// Backpressure: r_ready mirrors m_ready for the owner only; unready or non-owner strobes are dropped.
// Optional idle-owner watchdog with timeout_irq output: define I2C_ARB_TIMEOUT_EN.
module i2c_cmd_arbiter #(
  parameter int N_REQ     = 2,
  parameter int TIMEOUT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   r_req,
  output logic [N_REQ-1:0]   r_gnt,
  input  logic [2*N_REQ-1:0] r_cmd,
  input  logic [8*N_REQ-1:0] r_data_in,
  input  logic [N_REQ-1:0]   r_ack_in,
  input  logic [N_REQ-1:0]   r_stb,
  output logic [N_REQ-1:0]   r_ready,
  output logic [7:0]         r_data_out,
  output logic               r_ack_out,
  output logic [1:0]         m_cmd,
  output logic [7:0]         m_data_in,
  output logic               m_ack_in,
  output logic               m_stb,
  input  logic               m_ready,
  input  logic [7:0]         m_data_out,
  input  logic               m_ack_out
`ifdef I2C_ARB_TIMEOUT_EN
  ,
  output logic               timeout_irq
`endif
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [1:0] CMD_START = 2'b00;
  localparam logic [1:0] CMD_STOP  = 2'b01;

  typedef enum logic [1:0] {S_IDLE, S_OWNED, S_AUTO_STOP, S_WAIT_DONE} state_t;

  if (N_REQ < 1 || N_REQ > 8 || TIMEOUT_W < 1) begin : g_param_check
    $error("i2c_cmd_arbiter: N_REQ must be 1..8 and TIMEOUT_W at least 1");
  end

  state_t           r_state;
  logic [PTR_W-1:0] r_owner;
  logic [PTR_W-1:0] r_rr_ptr;
  logic             r_open;

  logic [PTR_W-1:0] w_sel_hi;
  logic [PTR_W-1:0] w_sel_lo;
  logic [PTR_W-1:0] w_sel;
  logic             w_hi_found;
  logic [PTR_W-1:0] w_owner_inc;
  logic [1:0]       w_own_cmd;
  logic [7:0]       w_own_data;
  logic             w_own_ack;
  logic             w_owned;
  logic             w_own_req;
  logic             w_acc_stb;
  logic             w_acc_start;
  logic             w_acc_stop;

  assign w_owned     = (r_state == S_OWNED);
  assign r_ready     = r_gnt & {N_REQ{m_ready & w_owned}};
  assign w_own_req   = |(r_req & r_gnt);
  // r_ready has at most the owner's bit set, so this is r_stb[owner] & r_ready[owner]
  assign w_acc_stb   = |(r_stb & r_ready);
  assign w_acc_start = w_acc_stb & (w_own_cmd == CMD_START);
  assign w_acc_stop  = w_acc_stb & (w_own_cmd == CMD_STOP);
  assign w_owner_inc = (r_owner == PTR_W'(N_REQ - 1)) ? '0 : r_owner + PTR_W'(1);
  assign r_data_out  = m_data_out;
  assign r_ack_out   = m_ack_out;

`ifdef I2C_ARB_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] r_timer;
  logic                 r_timeout_irq;
  logic                 w_tmo;
  // a strobe accepted in the same cycle the counter saturates keeps the owner alive
  assign w_tmo       = r_open & (&r_timer) & ~w_acc_stb;
  assign timeout_irq = r_timeout_irq;
`endif

  // Round-robin pick: lowest requester at or above rr_ptr, else lowest requester overall (wrap)
  always_comb begin
    w_sel_hi   = '0;
    w_sel_lo   = '0;
    w_hi_found = 1'b0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (r_req[i]) begin
        w_sel_lo = PTR_W'(i);
        if (PTR_W'(i) >= r_rr_ptr) begin
          w_sel_hi   = PTR_W'(i);
          w_hi_found = 1'b1;
        end
      end
    end
    w_sel = w_hi_found ? w_sel_hi : w_sel_lo;
  end

  // Select the owner's command slice
  always_comb begin
    w_own_cmd  = 2'b00;
    w_own_data = 8'h00;
    w_own_ack  = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_owner == PTR_W'(i)) begin
        w_own_cmd  = r_cmd[2*i +: 2];
        w_own_data = r_data_in[8*i +: 8];
        w_own_ack  = r_ack_in[i];
      end
    end
  end

  // Drive the master port: owner pass-through, or the arbiter's own STOP while cleaning up
  always_comb begin
    m_cmd     = 2'b00;
    m_data_in = 8'h00;
    m_ack_in  = 1'b0;
    m_stb     = 1'b0;
    case (r_state)
      S_OWNED: begin
        m_cmd     = w_own_cmd;
        m_data_in = w_own_data;
        m_ack_in  = w_own_ack;
        m_stb     = w_acc_stb;
      end
      S_AUTO_STOP: begin
        m_cmd = CMD_STOP;
        m_stb = m_ready;
      end
      default: ;
    endcase
  end

  // Arbitration FSM: grant, track open transaction, close abandoned ones, rotate priority
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_gnt    <= '0;
      r_owner  <= '0;
      r_rr_ptr <= '0;
      r_open   <= 1'b0;
`ifdef I2C_ARB_TIMEOUT_EN
      r_timer       <= '0;
      r_timeout_irq <= 1'b0;
`endif
    end else begin
`ifdef I2C_ARB_TIMEOUT_EN
      r_timeout_irq <= 1'b0;
      r_timer       <= '0;
`endif
      case (r_state)
        S_IDLE: begin
          if (|r_req && m_ready) begin
            r_owner <= w_sel;
            r_gnt   <= N_REQ'(1) << w_sel;
            r_state <= S_OWNED;
          end
        end
        S_OWNED: begin
          if (w_acc_start) begin
            r_open <= 1'b1;
          end else if (w_acc_stop) begin
            r_open <= 1'b0;
          end
          if (w_acc_stop) begin
            // a STOP in the same cycle as the request dropping needs no extra STOP
            r_gnt   <= '0;
            r_state <= S_WAIT_DONE;
          end else if (!w_own_req) begin
            r_gnt <= '0;
            if (r_open || w_acc_start) begin
              r_state <= S_AUTO_STOP;
            end else begin
              r_state  <= S_IDLE;
              r_rr_ptr <= w_owner_inc;
            end
          end
`ifdef I2C_ARB_TIMEOUT_EN
          else if (w_tmo) begin
            r_gnt         <= '0;
            r_state       <= S_AUTO_STOP;
            r_timeout_irq <= 1'b1;
          end else if (!w_acc_stb && r_open && m_ready) begin
            r_timer <= r_timer + TIMEOUT_W'(1);
          end else if (!w_acc_stb) begin
            r_timer <= r_timer;
          end
`endif
        end
        S_AUTO_STOP: begin
          if (m_ready) begin
            r_open  <= 1'b0;
            r_state <= S_WAIT_DONE;
          end
        end
        S_WAIT_DONE: begin
          if (m_ready) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= w_owner_inc;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
